// File: rtl/ct_fadd_close_s2_h_if.sv
// EX1->EX2 close-path bundle for the half-precision FP adder.
// The master drives stage-1 results and pipeline control; the slave returns EX2 results.
interface ct_fadd_close_s2_h_if;
   logic        ex1_pipe_vld;
   logic [11:0] ex1_close_sum;
   logic        ex1_close_op_chg;
   logic [5:0]  ex1_ff1_pred;
   logic [11:0] ex1_ff1_pred_onehot;
   logic [4:0]  ex1_exp;
   logic        ex1_sign;
   logic [2:0]  ex1_rm;
   logic        ex2_stall;
   logic        pipe_flush;

   logic        ex2_close_vld;
   logic [11:0] ex2_close_mant;
   logic [4:0]  ex2_close_exp;
   logic        ex2_close_sign;
   logic        ex2_close_zero;
   logic        ex2_close_denorm;
   logic        ex2_ff1_err;

   modport master (
      output ex1_pipe_vld, ex1_close_sum, ex1_close_op_chg, ex1_ff1_pred,
             ex1_ff1_pred_onehot, ex1_exp, ex1_sign, ex1_rm, ex2_stall, pipe_flush,
      input  ex2_close_vld, ex2_close_mant, ex2_close_exp, ex2_close_sign,
             ex2_close_zero, ex2_close_denorm, ex2_ff1_err
   );

   modport slave (
      input  ex1_pipe_vld, ex1_close_sum, ex1_close_op_chg, ex1_ff1_pred,
             ex1_ff1_pred_onehot, ex1_exp, ex1_sign, ex1_rm, ex2_stall, pipe_flush,
      output ex2_close_vld, ex2_close_mant, ex2_close_exp, ex2_close_sign,
             ex2_close_zero, ex2_close_denorm, ex2_ff1_err
   );
endinterface

// File: rtl/ct_fadd_close_s2_h.sv
// Half-precision FP adder close path, stage 2: registers EX1 results, then takes the
// magnitude, normalizes with LZA correction, and adjusts the exponent in EX2.
module ct_fadd_close_s2_h #(
   parameter logic [2:0] RDN_ENC = 3'b010
) (
   input logic                 forever_cpuclk,
   input logic                 cpurst_b,
   ct_fadd_close_s2_h_if.slave bus
);

   logic        vld_q,    vld_d;
   logic [11:0] sum_q,    sum_d;
   logic        op_chg_q, op_chg_d;
   logic [5:0]  pred_q,   pred_d;
   logic [11:0] onehot_q, onehot_d;
   logic [4:0]  exp_q,    exp_d;
   logic        sign_q,   sign_d;
   logic [2:0]  rm_q,     rm_d;

   always_comb begin
      vld_d    = vld_q;
      sum_d    = sum_q;
      op_chg_d = op_chg_q;
      pred_d   = pred_q;
      onehot_d = onehot_q;
      exp_d    = exp_q;
      sign_d   = sign_q;
      rm_d     = rm_q;
      if (bus.pipe_flush) begin
         vld_d = 1'b0;
      end else if (!bus.ex2_stall) begin
         vld_d = bus.ex1_pipe_vld;
         // Data holds across bubbles so idle cycles do not toggle the datapath.
         if (bus.ex1_pipe_vld) begin
            sum_d    = bus.ex1_close_sum;
            op_chg_d = bus.ex1_close_op_chg;
            pred_d   = bus.ex1_ff1_pred;
            onehot_d = bus.ex1_ff1_pred_onehot;
            exp_d    = bus.ex1_exp;
            sign_d   = bus.ex1_sign;
            rm_d     = bus.ex1_rm;
         end
      end
   end

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         vld_q    <= 1'b0;
         sum_q    <= '0;
         op_chg_q <= 1'b0;
         pred_q   <= '0;
         onehot_q <= '0;
         exp_q    <= '0;
         sign_q   <= 1'b0;
         rm_q     <= '0;
      end else begin
         vld_q    <= vld_d;
         sum_q    <= sum_d;
         op_chg_q <= op_chg_d;
         pred_q   <= pred_d;
         onehot_q <= onehot_d;
         exp_q    <= exp_d;
         sign_q   <= sign_d;
         rm_q     <= rm_d;
      end
   end

   logic [11:0] mag;
   logic [11:0] s1;
   logic [11:0] s_norm;
   logic        err;
   logic [5:0]  tshift;
   logic [5:0]  exp6;
   logic        is_zero;
   logic [11:0] mant_o;
   logic [4:0]  exp_o;
   logic        sign_o;
   logic        denorm_o;
   logic        err_o;

   always_comb begin
      mag     = op_chg_q ? (12'h000 - sum_q) : sum_q;
      is_zero = (mag == 12'h000);
      s1      = '0;
      // onehot_q[11] selects a shift of 0, onehot_q[0] a shift of 11.
      for (int unsigned i = 0; i < 12; i++) begin
         if (onehot_q[4'(11 - i)]) s1 = s1 | (mag << i);
      end
      err      = ~s1[11] & (pred_q != 6'd11);
      s_norm   = err ? (s1 << 1) : s1;
      tshift   = pred_q + {5'd0, err};
      exp6     = {1'b0, exp_q};
      mant_o   = s_norm;
      exp_o    = '0;
      denorm_o = 1'b0;
      err_o    = err;
      sign_o   = sign_q ^ op_chg_q;
      if (exp6 > tshift) begin
         exp_o = 5'(exp6 - tshift);
      end else begin
         mant_o   = mag << (exp_q - 5'd1);
         denorm_o = 1'b1;
      end
      if (is_zero) begin
         mant_o   = '0;
         exp_o    = '0;
         denorm_o = 1'b0;
         err_o    = 1'b0;
         sign_o   = (rm_q == RDN_ENC);
      end
   end

   assign bus.ex2_close_vld    = vld_q;
   assign bus.ex2_close_mant   = mant_o;
   assign bus.ex2_close_exp    = exp_o;
   assign bus.ex2_close_sign   = sign_o;
   assign bus.ex2_close_zero   = is_zero;
   assign bus.ex2_close_denorm = denorm_o;
   assign bus.ex2_ff1_err      = err_o;

endmodule

// File: doc/ct_fadd_close_s2_h.md
Name: ct_fadd_close_s2_h

Overview:
- Half-precision close-path stage 2 of the FP adder; sits directly downstream of close-path stage 1.
- Registers the stage-1 results at the EX1/EX2 boundary.
- In EX2 it takes the magnitude of the difference, left-normalizes it using the leading-one prediction (with a one-bit correction), and adjusts the exponent.
- Produces sign, zero and denormal flags for the rounding stage.

Parameters:
- RDN_ENC, 3'b010, rounding-mode encoding for round-down; selects the sign of an exact-zero result.

Ports:
- forever_cpuclk  in  1  clock
- cpurst_b  in  1  asynchronous active-low reset
- ex1_pipe_vld  in  1  EX1 close-path result valid
- ex1_close_sum  in  12  two's-complement difference adder0-adder1; [0] is the guard bit
- ex1_close_op_chg  in  1  difference negative (equals ex1_close_sum[11])
- ex1_ff1_pred  in  6  predicted leading-one position, 0 = bit 11, 11 = bit 0
- ex1_ff1_pred_onehot  in  12  one-hot of the same prediction, [11] = position 0
- ex1_exp  in  5  effective larger exponent, always >= 1
- ex1_sign  in  1  sign of operand 0
- ex1_rm  in  3  rounding mode
- ex2_stall  in  1  EX2 cannot advance
- pipe_flush  in  1  kill the in-flight operation
- ex2_close_vld  out  1  EX2 result valid
- ex2_close_mant  out  12  normalized magnitude, [11] = hidden bit, [0] = guard
- ex2_close_exp  out  5  biased result exponent
- ex2_close_sign  out  1  result sign
- ex2_close_zero  out  1  exact zero result
- ex2_close_denorm  out  1  result is subnormal
- ex2_ff1_err  out  1  prediction was one position short and was corrected

Behaviour:
- **Reset:** asynchronous on cpurst_b low.
  - All pipeline registers clear to 0 and ex2_close_vld = 0.
  - Outputs are then: mant 0, exp 0, zero 1, sign 0, denorm 0, ff1_err 0.
- **Pipeline control:** one register stage; all outputs are combinational from the EX2 registers. Latency is 1 cycle.
  - Priority: pipe_flush > ex2_stall > load.
  - Flush: ex2_close_vld <= 0 next edge; data registers don't care.
  - Stall (no flush): all registers hold, including vld.
  - Otherwise: vld <= ex1_pipe_vld. Data registers load only when ex1_pipe_vld = 1; otherwise they hold, so no bubble toggling.
- **Magnitude:** mag = op_chg ? (12'h000 - sum) : sum, using the registered values.
- **Zero:**
  - zero = (mag == 0). The registered prediction is ignored in this case (stage-1 one-hot is X for a zero input).
  - Outputs: mant 0, exp 0, denorm 0, ff1_err 0.
  - sign = (rm == RDN_ENC).
- **Prediction:** p = pred, range 0..11. The actual leading one is at position p or p+1.
- **Shift:**
  - s1 = mag << p, implemented as a one-hot-selected shifter from the registered onehot.
  - If s1[11] == 0 (and p < 11): s = s1 << 1, ff1_err = 1, total shift t = p+1.
  - Else: ff1_err = 0, t = p.
- **Exponent:**
  - If exp > t: exp_out = exp - t, mant = shifted value, denorm = 0.
  - Else: shift is limited to exp-1, mant = mag << (exp-1), exp_out = 0, denorm = 1. ff1_err keeps its computed value.
  - Subtraction is 6-bit internally; no wrap into a large positive exponent.
- **Sign:** sign = ex1_sign ^ op_chg for nonzero results.
- **Outputs when invalid:** outputs still reflect the held registers when vld = 0. Consumers qualify them with ex2_close_vld.

Test Plan:
- **Correct prediction:** sum 12'h400, op_chg 0, pred 1 (onehot 12'h400), exp 15, sign 0 -> next cycle vld 1, mant 12'h800, exp 14, sign 0, ff1_err 0.
- **Prediction one short:** sum 12'h200, pred 1, exp 15 -> mant 12'h800, exp 13, ff1_err 1.
- **Negative difference:** sum 12'hC00, op_chg 1, pred 1, exp 10, sign 0 -> mag 12'h400, mant 12'h800, exp 9, sign 1.
- **Exact zero:** sum 12'h000, rm 3'b010 -> zero 1, sign 1, mant 0, exp 0. Repeat with rm 3'b000 -> sign 0.
- **Denormal clamp:** sum 12'h010, pred 7, exp 3 -> shift clamped to 2, mant 12'h040, exp 0, denorm 1.
- **Handshake and reset:**
  - Load A (sum 12'h400) then hold ex2_stall = 1 while presenting B (sum 12'h200) -> outputs stay A.
  - Release stall -> B appears one cycle later.
  - pipe_flush together with stall -> vld 0 next edge.
  - Assert cpurst_b low mid-operation -> vld 0 immediately, without waiting for a clock edge.
